// File: rtl/core_pkg.sv
// Shared core definitions: write-data select codes, hazard FSM states and
// the register-match helper used by hazard detection and forwarding.
package core_pkg;

   localparam logic [1:0] WD_SEL_ALU  = 2'b00;
   localparam logic [1:0] WD_SEL_DRAM = 2'b01;
   localparam logic [1:0] WD_SEL_PC4  = 2'b10;
   localparam logic [1:0] WD_SEL_IMM  = 2'b11;

   localparam int unsigned REG_W  = 5;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 3;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      REDIRECT   = 2'd2
   } hazard_state_t;

   // A stage result is visible to a reader only if it really writes a non-x0 register
   // that the ID instruction really reads.
   function automatic logic reg_hit(
      input logic             we,
      input logic [REG_W-1:0] wr,
      input logic [REG_W-1:0] rs,
      input logic             re
   );
      return we && (wr != 5'd0) && (wr == rs) && re;
   endfunction

endpackage

// File: rtl/fwd_sel.sv
// Per-operand forwarding mux: picks the youngest matching producer among
// EX (non-load), MEM and WB and returns its write data.
module fwd_sel
   import core_pkg::*;
(
   input  logic [REG_W-1:0]  rs,
   input  logic              re,
   input  logic [REG_W-1:0]  ex_wR,
   input  logic              ex_rf_we,
   input  logic [1:0]        ex_wd_sel,
   input  logic [DATA_W-1:0] ex_wD,
   input  logic [REG_W-1:0]  mem_wR,
   input  logic              mem_rf_we,
   input  logic [DATA_W-1:0] mem_wD,
   input  logic [REG_W-1:0]  wb_wR,
   input  logic              wb_rf_we,
   input  logic [DATA_W-1:0] wb_wD,
   output logic              op,
   output logic [DATA_W-1:0] fd
);

   logic ex_hit_s;
   logic mem_hit_s;
   logic wb_hit_s;

   // A load in EX has no data yet; that case is covered by the load-use stall.
   assign ex_hit_s  = reg_hit(ex_rf_we, ex_wR, rs, re) && (ex_wd_sel != WD_SEL_DRAM);
   assign mem_hit_s = reg_hit(mem_rf_we, mem_wR, rs, re);
   assign wb_hit_s  = reg_hit(wb_rf_we, wb_wR, rs, re);

   // Priority select, youngest producer first.
   always_comb begin
      op = 1'b0;
      fd = 32'd0;
      if (ex_hit_s) begin
         op = 1'b1;
         fd = ex_wD;
      end else if (mem_hit_s) begin
         op = 1'b1;
         fd = mem_wD;
      end else if (wb_hit_s) begin
         op = 1'b1;
         fd = wb_wD;
      end else begin
         op = 1'b0;
         fd = 32'd0;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall and redirect flush sequencing,
// operand forwarding into ID/EX, and stall/flush event counters.
module hazard_ctrl
   import core_pkg::*;
#(
   parameter int unsigned LOAD_STALL_CYCLES = 1,  // 1..7
   parameter int unsigned REDIRECT_CYCLES   = 1   // 1..7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_W-1:0]  id_rs1,
   input  logic [REG_W-1:0]  id_rs2,
   input  logic              id_re1,
   input  logic              id_re2,
   input  logic [REG_W-1:0]  ex_wR,
   input  logic              ex_rf_we,
   input  logic [1:0]        ex_wd_sel,
   input  logic [DATA_W-1:0] ex_wD,
   input  logic              ex_redirect,
   input  logic [REG_W-1:0]  mem_wR,
   input  logic              mem_rf_we,
   input  logic [DATA_W-1:0] mem_wD,
   input  logic [REG_W-1:0]  wb_wR,
   input  logic              wb_rf_we,
   input  logic [DATA_W-1:0] wb_wD,
   output logic              stall_pc,
   output logic              stall_if_id,
   output logic              flush_if_id,
   output logic              flush_id_ex,
   output logic              rD1_op,
   output logic              rD2_op,
   output logic [DATA_W-1:0] rD1_f,
   output logic [DATA_W-1:0] rD2_f,
   output logic [DATA_W-1:0] stall_cnt,
   output logic [DATA_W-1:0] flush_cnt
);

   localparam bit              LS_MULTI  = (LOAD_STALL_CYCLES > 32'd1);
   localparam bit              RD_MULTI  = (REDIRECT_CYCLES > 32'd1);
   localparam logic [CNT_W-1:0] LS_RELOAD = CNT_W'(LOAD_STALL_CYCLES - 32'd1);
   localparam logic [CNT_W-1:0] RD_RELOAD = CNT_W'(REDIRECT_CYCLES - 32'd1);

   hazard_state_t     state_r;
   hazard_state_t     state_nxt_s;
   logic [CNT_W-1:0]  cnt_r;
   logic [CNT_W-1:0]  cnt_nxt_s;
   logic [DATA_W-1:0] stall_cnt_r;
   logic [DATA_W-1:0] flush_cnt_r;

   logic lu_s;
   logic stall_s;
   logic flush_if_id_s;
   logic flush_id_ex_s;
   logic stall_inc_s;
   logic flush_inc_s;

   assign lu_s = ex_rf_we && (ex_wd_sel == WD_SEL_DRAM) && (ex_wR != 5'd0) &&
                 (reg_hit(1'b1, ex_wR, id_rs1, id_re1) ||
                  reg_hit(1'b1, ex_wR, id_rs2, id_re2));

   // Next-state, remaining-cycle count and hazard controls for the current cycle.
   always_comb begin
      state_nxt_s   = state_r;
      cnt_nxt_s     = cnt_r;
      stall_s       = 1'b0;
      flush_if_id_s = 1'b0;
      flush_id_ex_s = 1'b0;
      stall_inc_s   = 1'b0;
      flush_inc_s   = 1'b0;
      case (state_r)
         RUN: begin
            if (ex_redirect) begin
               // A redirect also squashes any load in EX, so it wins over load-use.
               flush_if_id_s = 1'b1;
               flush_id_ex_s = 1'b1;
               flush_inc_s   = 1'b1;
               if (RD_MULTI) begin
                  state_nxt_s = REDIRECT;
                  cnt_nxt_s   = RD_RELOAD;
               end else begin
                  state_nxt_s = RUN;
                  cnt_nxt_s   = 3'd0;
               end
            end else if (lu_s) begin
               stall_s       = 1'b1;
               flush_id_ex_s = 1'b1;
               stall_inc_s   = 1'b1;
               if (LS_MULTI) begin
                  state_nxt_s = LOAD_STALL;
                  cnt_nxt_s   = LS_RELOAD;
               end else begin
                  state_nxt_s = RUN;
                  cnt_nxt_s   = 3'd0;
               end
            end else begin
               state_nxt_s = RUN;
               cnt_nxt_s   = 3'd0;
            end
         end
         LOAD_STALL: begin
            // EX holds a bubble here, so a redirect cannot originate from it.
            stall_s       = 1'b1;
            flush_id_ex_s = 1'b1;
            stall_inc_s   = 1'b1;
            if (cnt_r <= 3'd1) begin
               state_nxt_s = RUN;
               cnt_nxt_s   = 3'd0;
            end else begin
               state_nxt_s = LOAD_STALL;
               cnt_nxt_s   = cnt_r - 3'd1;
            end
         end
         REDIRECT: begin
            flush_if_id_s = 1'b1;
            flush_id_ex_s = 1'b1;
            if (cnt_r <= 3'd1) begin
               state_nxt_s = RUN;
               cnt_nxt_s   = 3'd0;
            end else begin
               state_nxt_s = REDIRECT;
               cnt_nxt_s   = cnt_r - 3'd1;
            end
         end
         default: begin
            state_nxt_s = RUN;
            cnt_nxt_s   = 3'd0;
         end
      endcase
   end

   // State, count and event counters; reset aborts any sequence in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= RUN;
         cnt_r       <= 3'd0;
         stall_cnt_r <= 32'd0;
         flush_cnt_r <= 32'd0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         if (stall_inc_s) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
         end
         if (flush_inc_s) begin
            flush_cnt_r <= flush_cnt_r + 32'd1;
         end
      end
   end

   assign stall_pc    = stall_s & ~rst;
   assign stall_if_id = stall_s & ~rst;
   assign flush_if_id = flush_if_id_s & ~rst;
   assign flush_id_ex = flush_id_ex_s & ~rst;
   assign stall_cnt   = stall_cnt_r;
   assign flush_cnt   = flush_cnt_r;

   fwd_sel u_fwd1 (
      .rs        (id_rs1),
      .re        (id_re1),
      .ex_wR     (ex_wR),
      .ex_rf_we  (ex_rf_we),
      .ex_wd_sel (ex_wd_sel),
      .ex_wD     (ex_wD),
      .mem_wR    (mem_wR),
      .mem_rf_we (mem_rf_we),
      .mem_wD    (mem_wD),
      .wb_wR     (wb_wR),
      .wb_rf_we  (wb_rf_we),
      .wb_wD     (wb_wD),
      .op        (rD1_op),
      .fd        (rD1_f)
   );

   fwd_sel u_fwd2 (
      .rs        (id_rs2),
      .re        (id_re2),
      .ex_wR     (ex_wR),
      .ex_rf_we  (ex_rf_we),
      .ex_wd_sel (ex_wd_sel),
      .ex_wD     (ex_wD),
      .mem_wR    (mem_wR),
      .mem_rf_we (mem_rf_we),
      .mem_wD    (mem_wD),
      .wb_wR     (wb_wR),
      .wb_rf_we  (wb_rf_we),
      .wb_wD     (wb_wD),
      .op        (rD2_op),
      .fd        (rD2_f)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: one instance with single-cycle
// latencies (a) and one with LOAD_STALL_CYCLES=3, REDIRECT_CYCLES=2 (b).
module tb_hazard_ctrl;
   import core_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rs1, id_rs2, ex_wR, mem_wR, wb_wR;
   logic        id_re1, id_re2, ex_rf_we, mem_rf_we, wb_rf_we, ex_redirect;
   logic [1:0]  ex_wd_sel;
   logic [31:0] ex_wD, mem_wD, wb_wD;

   logic        a_stall_pc, a_stall_if_id, a_flush_if_id, a_flush_id_ex, a_rD1_op, a_rD2_op;
   logic [31:0] a_rD1_f, a_rD2_f, a_stall_cnt, a_flush_cnt;
   logic        b_stall_pc, b_stall_if_id, b_flush_if_id, b_flush_id_ex, b_rD1_op, b_rD2_op;
   logic [31:0] b_rD1_f, b_rD2_f, b_stall_cnt, b_flush_cnt;

   always #5 clk = ~clk;

   hazard_ctrl #(.LOAD_STALL_CYCLES(1), .REDIRECT_CYCLES(1)) u_a (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_re1(id_re1), .id_re2(id_re2),
      .ex_wR(ex_wR), .ex_rf_we(ex_rf_we), .ex_wd_sel(ex_wd_sel), .ex_wD(ex_wD),
      .ex_redirect(ex_redirect), .mem_wR(mem_wR), .mem_rf_we(mem_rf_we), .mem_wD(mem_wD),
      .wb_wR(wb_wR), .wb_rf_we(wb_rf_we), .wb_wD(wb_wD),
      .stall_pc(a_stall_pc), .stall_if_id(a_stall_if_id), .flush_if_id(a_flush_if_id),
      .flush_id_ex(a_flush_id_ex), .rD1_op(a_rD1_op), .rD2_op(a_rD2_op),
      .rD1_f(a_rD1_f), .rD2_f(a_rD2_f), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
   );

   hazard_ctrl #(.LOAD_STALL_CYCLES(3), .REDIRECT_CYCLES(2)) u_b (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_re1(id_re1), .id_re2(id_re2),
      .ex_wR(ex_wR), .ex_rf_we(ex_rf_we), .ex_wd_sel(ex_wd_sel), .ex_wD(ex_wD),
      .ex_redirect(ex_redirect), .mem_wR(mem_wR), .mem_rf_we(mem_rf_we), .mem_wD(mem_wD),
      .wb_wR(wb_wR), .wb_rf_we(wb_rf_we), .wb_wD(wb_wD),
      .stall_pc(b_stall_pc), .stall_if_id(b_stall_if_id), .flush_if_id(b_flush_if_id),
      .flush_id_ex(b_flush_id_ex), .rD1_op(b_rD1_op), .rD2_op(b_rD2_op),
      .rD1_f(b_rD1_f), .rD2_f(b_rD2_f), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
   );

   // Observable selectors
   localparam int CTL_A = 0, CTL_B = 1, OP1 = 2, F1 = 3, OP2 = 4, F2 = 5;
   localparam int SC_A = 6, FC_A = 7, SC_B = 8, FC_B = 9, ST_B = 10;
   // {stall_pc, stall_if_id, flush_if_id, flush_id_ex}
   localparam logic [31:0] C_NONE = 32'h0, C_STALL = 32'hD, C_FLUSH = 32'h3;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         CTL_A:   return {28'd0, a_stall_pc, a_stall_if_id, a_flush_if_id, a_flush_id_ex};
         CTL_B:   return {28'd0, b_stall_pc, b_stall_if_id, b_flush_if_id, b_flush_id_ex};
         OP1:     return {31'd0, a_rD1_op};
         F1:      return a_rD1_f;
         OP2:     return {31'd0, a_rD2_op};
         F2:      return a_rD2_f;
         SC_A:    return a_stall_cnt;
         FC_A:    return a_flush_cnt;
         SC_B:    return b_stall_cnt;
         FC_B:    return b_flush_cnt;
         ST_B:    return 32'(u_b.state_r);
         default: return 32'hxxxx_xxxx;
      endcase
   endfunction

   task automatic exp_v(input string tag, input int sel, input logic [31:0] val);
      sb_q.push_back('{tag, sel, val});
   endtask

   task automatic check_all();
      logic [31:0] obs;
      exp_t        e;
      while (sb_q.size() > 0) begin
         e   = sb_q.pop_front();
         obs = observe(e.sel);
         vectors++;
         assert (obs === e.val) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic idle();
      id_rs1 = 5'd0; id_rs2 = 5'd0; id_re1 = 1'b0; id_re2 = 1'b0;
      ex_wR = 5'd0; ex_rf_we = 1'b0; ex_wd_sel = WD_SEL_ALU; ex_wD = 32'd0; ex_redirect = 1'b0;
      mem_wR = 5'd0; mem_rf_we = 1'b0; mem_wD = 32'd0;
      wb_wR = 5'd0; wb_rf_we = 1'b0; wb_wD = 32'd0;
   endtask

   task automatic load_x5();   // lw x5 in EX, add reading x5 in ID
      idle();
      ex_rf_we = 1'b1; ex_wd_sel = WD_SEL_DRAM; ex_wR = 5'd5; ex_wD = 32'hDEAD_0000;
      id_rs1 = 5'd5; id_re1 = 1'b1;
   endtask

   task automatic load_in_mem();
      idle();
      mem_rf_we = 1'b1; mem_wR = 5'd5; mem_wD = 32'h0000_1234;
      id_rs1 = 5'd5; id_re1 = 1'b1;
   endtask

   task automatic fwd_x7();
      idle();
      ex_rf_we = 1'b1; ex_wd_sel = WD_SEL_ALU; ex_wR = 5'd7; ex_wD = 32'hA;
      mem_rf_we = 1'b1; mem_wR = 5'd7; mem_wD = 32'hB;
      wb_rf_we = 1'b1; wb_wR = 5'd7; wb_wD = 32'hC;
      id_rs2 = 5'd7; id_re2 = 1'b1;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      // Reset gates controls even with a hazard present
      @(negedge clk); load_x5();
      exp_v("rst_ctl_a", CTL_A, C_NONE); exp_v("rst_ctl_b", CTL_B, C_NONE);
      #1 check_all();
      @(negedge clk); rst = 1'b0; idle();
      exp_v("idle_ctl_a", CTL_A, C_NONE); exp_v("idle_ctl_b", CTL_B, C_NONE);
      exp_v("rst_sc_a", SC_A, 32'd0); exp_v("rst_fc_a", FC_A, 32'd0);
      exp_v("rst_sc_b", SC_B, 32'd0); exp_v("rst_fc_b", FC_B, 32'd0);
      exp_v("rst_state_b", ST_B, 32'(RUN));
      #1 check_all();

      // Load-use: single-cycle (a) and three-cycle (b) stall
      @(negedge clk); load_x5();
      exp_v("lu_ctl_a", CTL_A, C_STALL); exp_v("lu_ctl_b", CTL_B, C_STALL);
      exp_v("lu_no_ex_fwd_op", OP1, 32'd0); exp_v("lu_no_ex_fwd_f", F1, 32'd0);
      #1 check_all();
      @(negedge clk); load_in_mem();
      exp_v("lu2_ctl_a", CTL_A, C_NONE); exp_v("lu2_ctl_b", CTL_B, C_STALL);
      exp_v("lu2_mem_op", OP1, 32'd1); exp_v("lu2_mem_f", F1, 32'h1234);
      exp_v("lu2_sc_a", SC_A, 32'd1); exp_v("lu2_sc_b", SC_B, 32'd1);
      #1 check_all();
      @(negedge clk);
      exp_v("lu3_ctl_b", CTL_B, C_STALL); exp_v("lu3_sc_b", SC_B, 32'd2);
      #1 check_all();
      @(negedge clk);
      exp_v("lu4_ctl_b", CTL_B, C_NONE); exp_v("lu4_state_b", ST_B, 32'(RUN));
      exp_v("lu4_sc_b", SC_B, 32'd3); exp_v("lu4_sc_a", SC_A, 32'd1);
      #1 check_all();

      // Redirect together with load-use: redirect wins
      @(negedge clk); load_x5(); ex_redirect = 1'b1;
      exp_v("rd_ctl_a", CTL_A, C_FLUSH); exp_v("rd_ctl_b", CTL_B, C_FLUSH);
      #1 check_all();
      @(negedge clk); idle();
      exp_v("rd2_ctl_a", CTL_A, C_NONE); exp_v("rd2_ctl_b", CTL_B, C_FLUSH);
      exp_v("rd2_fc_a", FC_A, 32'd1); exp_v("rd2_fc_b", FC_B, 32'd1);
      exp_v("rd2_sc_a", SC_A, 32'd1); exp_v("rd2_sc_b", SC_B, 32'd3);
      #1 check_all();
      @(negedge clk);
      exp_v("rd3_ctl_b", CTL_B, C_NONE); exp_v("rd3_state_b", ST_B, 32'(RUN));
      exp_v("rd3_fc_b", FC_B, 32'd1);
      #1 check_all();

      // Redirect during LOAD_STALL is ignored
      @(negedge clk); load_x5();
      exp_v("ls_ctl_a", CTL_A, C_STALL); exp_v("ls_ctl_b", CTL_B, C_STALL);
      #1 check_all();
      @(negedge clk); idle(); ex_redirect = 1'b1;
      exp_v("lsrd_ctl_a", CTL_A, C_FLUSH); exp_v("lsrd_ctl_b", CTL_B, C_STALL);
      exp_v("lsrd_sc_b", SC_B, 32'd4);
      #1 check_all();
      @(negedge clk); idle();
      exp_v("lsrd2_ctl_a", CTL_A, C_NONE); exp_v("lsrd2_ctl_b", CTL_B, C_STALL);
      exp_v("lsrd2_fc_a", FC_A, 32'd2); exp_v("lsrd2_fc_b", FC_B, 32'd1);
      exp_v("lsrd2_sc_b", SC_B, 32'd5);
      #1 check_all();
      @(negedge clk);
      exp_v("lsrd3_ctl_b", CTL_B, C_NONE); exp_v("lsrd3_sc_b", SC_B, 32'd6);
      exp_v("lsrd3_sc_a", SC_A, 32'd2);
      #1 check_all();

      // Forwarding priority on rs2
      @(negedge clk); fwd_x7();
      exp_v("fwd_ex_op", OP2, 32'd1); exp_v("fwd_ex_f", F2, 32'hA);
      exp_v("fwd_rs1_op", OP1, 32'd0); exp_v("fwd_rs1_f", F1, 32'd0);
      exp_v("fwd_ctl_a", CTL_A, C_NONE);
      #1 check_all();
      @(negedge clk); ex_rf_we = 1'b0;
      exp_v("fwd_mem_f", F2, 32'hB);
      #1 check_all();
      @(negedge clk); mem_rf_we = 1'b0;
      exp_v("fwd_wb_f", F2, 32'hC);
      #1 check_all();
      @(negedge clk); fwd_x7(); ex_wR = 5'd0; mem_wR = 5'd0; wb_wR = 5'd0; id_rs2 = 5'd0;
      exp_v("fwd_x0_op", OP2, 32'd0); exp_v("fwd_x0_f", F2, 32'd0);
      #1 check_all();
      @(negedge clk); fwd_x7(); id_re2 = 1'b0;
      exp_v("fwd_nore_op", OP2, 32'd0); exp_v("fwd_nore_f", F2, 32'd0);
      #1 check_all();
      @(negedge clk); fwd_x7(); ex_wd_sel = WD_SEL_DRAM;
      exp_v("fwd_ld_ctl_a", CTL_A, C_STALL); exp_v("fwd_ld_ctl_b", CTL_B, C_STALL);
      exp_v("fwd_ld_op", OP2, 32'd1); exp_v("fwd_ld_f", F2, 32'hB);
      #1 check_all();

      // Reset in the second cycle of b's three-cycle stall
      @(negedge clk); rst = 1'b1; load_x5();
      exp_v("mrst_ctl_a", CTL_A, C_NONE); exp_v("mrst_ctl_b", CTL_B, C_NONE);
      #1 check_all();
      @(negedge clk); rst = 1'b0; idle();
      exp_v("mrst2_ctl_a", CTL_A, C_NONE); exp_v("mrst2_ctl_b", CTL_B, C_NONE);
      exp_v("mrst2_state_b", ST_B, 32'(RUN));
      exp_v("mrst2_sc_a", SC_A, 32'd0); exp_v("mrst2_fc_a", FC_A, 32'd0);
      exp_v("mrst2_sc_b", SC_B, 32'd0); exp_v("mrst2_fc_b", FC_B, 32'd0);
      #1 check_all();

      // Stall counter wrap
      @(negedge clk); idle();
      force u_a.stall_cnt_r = 32'hFFFF_FFFF;
      #1 release u_a.stall_cnt_r;
      exp_v("wrap_pre_sc_a", SC_A, 32'hFFFF_FFFF);
      #1 check_all();
      @(negedge clk); load_x5();
      exp_v("wrap_ctl_a", CTL_A, C_STALL);
      #1 check_all();
      @(negedge clk); idle();
      exp_v("wrap_sc_a", SC_A, 32'd0); exp_v("wrap_ctl_a2", CTL_A, C_NONE);
      exp_v("wrap_ctl_b", CTL_B, C_STALL); exp_v("wrap_sc_b", SC_B, 32'd1);
      #1 check_all();
      @(negedge clk);
      exp_v("wrap2_ctl_b", CTL_B, C_STALL);
      #1 check_all();
      @(negedge clk);
      exp_v("wrap3_ctl_b", CTL_B, C_NONE); exp_v("wrap3_sc_b", SC_B, 32'd3);
      #1 check_all();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the five-stage core; sits beside the IF/ID and ID/EX pipeline registers.
- Detects load-use and control hazards, sequences multi-cycle stalls and redirect flushes, and drives the forwarding selects and data into the ID/EX register.
- Keeps stall and flush event counters for trace and debug.

Parameters:
- LOAD_STALL_CYCLES, 1, bubble cycles inserted per load-use hazard (DRAM read latency); legal range 1..7
- REDIRECT_CYCLES, 1, cycles IF/ID and ID/EX are flushed after a taken branch/jump (IROM latency); legal range 1..7

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- id_re1, id_re2  in  1 each  ID instruction actually reads rs1/rs2
- ex_wR  in  5  destination register in EX
- ex_rf_we  in  1  EX writes the register file
- ex_wd_sel  in  2  EX write-data select
- ex_wD  in  32  EX result (ALU/pc+4/imm)
- ex_redirect  in  1  branch taken or jump resolved in EX
- mem_wR, mem_rf_we, mem_wD  in  5/1/32  MEM-stage writeback info (wD already load data)
- wb_wR, wb_rf_we, wb_wD  in  5/1/32  WB-stage writeback info
- stall_pc  out  1  hold PC
- stall_if_id  out  1  hold IF/ID
- flush_if_id  out  1  clear IF/ID
- flush_id_ex  out  1  clear ID/EX (bubble)
- rD1_op, rD2_op  out  1 each  select forwarded operand
- rD1_f, rD2_f  out  32 each  forwarded operand data
- stall_cnt  out  32  total load-use bubble cycles
- flush_cnt  out  32  total redirect events

Behaviour:
- FSM states: RUN, LOAD_STALL, REDIRECT. A 3-bit down-counter cnt holds the remaining cycles.
- Load-use hazard (lu), combinational, is true when all of the following hold:
  - ex_rf_we=1
  - ex_wd_sel=WD_SEL_DRAM
  - ex_wR!=0
  - (id_re1 && id_rs1==ex_wR) || (id_re2 && id_rs2==ex_wR)
- RUN:
  - If ex_redirect: assert flush_if_id=flush_id_ex=1 this cycle. flush_cnt+1. If REDIRECT_CYCLES>1, go to REDIRECT with cnt=REDIRECT_CYCLES-1.
  - Else if lu: assert stall_pc=stall_if_id=flush_id_ex=1 this cycle. stall_cnt+1. If LOAD_STALL_CYCLES>1, go to LOAD_STALL with cnt=LOAD_STALL_CYCLES-1.
  - Redirect has priority over lu. A flushed load needs no stall.
- LOAD_STALL:
  - Each cycle asserts stall_pc, stall_if_id and flush_id_ex, and increments stall_cnt.
  - cnt decrements; when cnt reaches 1, return to RUN.
  - ex_redirect is ignored here, because EX holds a bubble.
- REDIRECT:
  - Each cycle asserts flush_if_id and flush_id_ex; stalls stay low.
  - cnt decrements; when cnt reaches 1, return to RUN.
- Outputs and latency:
  - All control outputs are combinational from state and inputs, with zero latency in the cycle of detection.
  - Each control output is 0 in RUN when no hazard is present.
- Forwarding, per operand n (combinational):
  - Priority is EX (only if ex_wd_sel!=WD_SEL_DRAM) > MEM > WB.
  - A stage matches when its rf_we=1, its wR!=0, its wR==id_rsn and id_ren=1.
  - On a match: rDn_op=1 and rDn_f is that stage's wD. With no match: rDn_op=0 and rDn_f=0.
  - x0 is never forwarded.
- Counters: 32-bit, wrap at 2^32-1 → 0.
- Reset:
  - Sync rst forces state=RUN, cnt=0, stall_cnt=0, flush_cnt=0.
  - While rst=1, all control outputs are 0.
  - Reset mid-stall or mid-redirect aborts immediately; in the next cycle the FSM is in RUN.

Decomposition:
- Shared package core_pkg holds:
  - WD_SEL_ALU=2'b00, WD_SEL_DRAM=2'b01, WD_SEL_PC4=2'b10, WD_SEL_IMM=2'b11
  - hazard_state_t enum {RUN, LOAD_STALL, REDIRECT}
- One natural sub-module: fwd_sel, the per-operand priority mux, instantiated twice.

Test Plan:
- lw x5 in EX (ex_wd_sel=01, ex_wR=5), ID add reads rs1=5 with re1=1, LOAD_STALL_CYCLES=1 → one cycle of stall_pc=stall_if_id=flush_id_ex=1; next cycle MEM matches, so rD1_op=1 and rD1_f=mem_wD=0x1234; stall_cnt=1.
- Same stimulus with LOAD_STALL_CYCLES=3 → exactly 3 stall cycles; FSM back in RUN on cycle 4; stall_cnt=3.
- ex_redirect=1 together with lu=1, REDIRECT_CYCLES=2 → 2 cycles of flush_if_id=flush_id_ex=1 and no stall; flush_cnt=1, stall_cnt=0.
- EX, MEM and WB all write x7 with wD 0xA, 0xB, 0xC, ID reads rs2=7 → rD2_f=0xA. Set ex_rf_we=0 → 0xB. Set mem_rf_we=0 → 0xC. Use x0 instead → rD2_op=0.
- Assert rst in the 2nd cycle of a 3-cycle LOAD_STALL → next cycle all outputs 0, state RUN, counters 0.
- Preload stall_cnt to 0xFFFFFFFF by forcing it, then trigger one load-use → stall_cnt=0.
